// File: rtl/serial_comparator.sv
// serial_comparator
//   Multi-cycle magnitude comparator. Two WIDTH-bit operands are latched on a
//   start request and scanned DIGIT bits per cycle, MSB first, so a wide
//   compare never sits in one combinational path. The first differing digit
//   decides lt/gt; if no digit differs the result is eq.
//   Signed compares are turned into unsigned ones by inverting the MSB of both
//   operands when they are latched (offset-binary trick).
//
//   Optional build macro: SERIAL_CMP_EARLY_EXIT_EN
//     defined   - leave RUN on the edge that records the first differing digit
//     undefined - always scan all NDIG digits (data-independent latency)
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   start        in   1      compare request, sampled only in IDLE
//   signed_mode  in   1      1 = two's-complement compare, sampled with start
//   a, b         in   WIDTH  operands, sampled with start
//   busy         out  1      high in RUN and DONE
//   done         out  1      one-cycle pulse, result valid from this cycle
//   lt, eq, gt   out  1      result flags, held until the next done
module serial_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sa_r, sa_s;
  logic [WIDTH-1:0] sb_r, sb_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             dec_r, dec_s;     // a differing digit has been seen
  logic             dgt_r, dgt_s;     // direction of that digit: 1 = a > b
  logic             busy_r, done_r, lt_r, eq_r, gt_r;
  logic             lt_s, eq_s, gt_s;

  logic [DIGIT-1:0] da_s, db_s;
  logic             diff_s, last_s, finish_s;

  assign da_s   = sa_r[WIDTH-1 -: DIGIT];
  assign db_s   = sb_r[WIDTH-1 -: DIGIT];
  assign diff_s = (da_s != db_s);
  assign last_s = (cnt_r == CW'(NDIG - 1));

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // Stop as soon as the deciding digit is recorded.
  assign finish_s = last_s | (~dec_r & diff_s);
`else
  assign finish_s = last_s;
`endif

  // Next-state, datapath and result logic.
  always_comb begin
    state_s = state_r;
    sa_s    = sa_r;
    sb_s    = sb_r;
    cnt_s   = cnt_r;
    dec_s   = dec_r;
    dgt_s   = dgt_r;
    lt_s    = lt_r;
    eq_s    = eq_r;
    gt_s    = gt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          sa_s    = signed_mode ? (a ^ MSB_MASK) : a;
          sb_s    = signed_mode ? (b ^ MSB_MASK) : b;
          cnt_s   = '0;
          dec_s   = 1'b0;
          dgt_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        sa_s  = sa_r << DIGIT;
        sb_s  = sb_r << DIGIT;
        cnt_s = cnt_r + CW'(1);
        // Only the first differing digit may set the direction.
        dec_s = dec_r | diff_s;
        dgt_s = dec_r ? dgt_r : (da_s > db_s);
        if (finish_s) begin
          state_s = DONE;
          eq_s    = ~dec_s;
          gt_s    = dec_s & dgt_s;
          lt_s    = dec_s & ~dgt_s;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sa_r    <= '0;
      sb_r    <= '0;
      cnt_r   <= '0;
      dec_r   <= 1'b0;
      dgt_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      lt_r    <= 1'b0;
      eq_r    <= 1'b0;
      gt_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      sa_r    <= sa_s;
      sb_r    <= sb_s;
      cnt_r   <= cnt_s;
      dec_r   <= dec_s;
      dgt_r   <= dgt_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      lt_r    <= lt_s;
      eq_r    <= eq_s;
      gt_r    <= gt_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign lt   = lt_r;
  assign eq   = eq_r;
  assign gt   = gt_r;

endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator
//   Self-checking bench for serial_comparator (WIDTH=8, DIGIT=2).
//   Table-driven compares plus hand-written multi-cycle sequences; expected
//   results and latencies are queued at each accepted start and checked when
//   done pulses.
module tb_serial_comparator;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy, done, lt, eq, gt;

  serial_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sm;
    logic [2:0]       exp;   // {lt, eq, gt}
  } vec_t;

  typedef struct {
    logic [2:0] exp;
    int         e0;
    int         k;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[14];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   brun = 0;
  int   blen = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                         input logic s);
    if (x == y) return 3'b010;
    if (s) return ($signed(x) < $signed(y)) ? 3'b100 : 3'b001;
    return (x < y) ? 3'b100 : 3'b001;
  endfunction

  function automatic int ref_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int first;
    first = NDIG;
    for (int d = NDIG - 1; d >= 0; d--)
      if (x[WIDTH-1-DIGIT*d -: DIGIT] != y[WIDTH-1-DIGIT*d -: DIGIT]) first = d + 1;
    return EARLY_EN ? first : NDIG;
  endfunction

  // Observes done pulses and busy run lengths.
  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (busy) brun++;
      else begin
        if (brun != 0) blen = brun;
        brun = 0;
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result_lt_eq_gt", int'({lt, eq, gt}), int'(e.exp));
          chk("latency", cyc - e.e0, e.k);
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk); #1;
    while ((busy || done) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  // Drive one compare from idle; operands are scrambled right after the start edge.
  task automatic start_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic s, input logic [2:0] exp);
    a = x; b = y; signed_mode = s; start = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{exp: exp, e0: cyc, k: ref_k(x, y)});
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    signed_mode = ~s;
  endtask

  initial begin
    int d0, prev, prevk, kk;
    logic [WIDTH-1:0] x, y;
    logic s;

    vecs[0]  = '{a: 8'h01, b: 8'h03, sm: 1'b0, exp: 3'b100};
    vecs[1]  = '{a: 8'hA5, b: 8'hA5, sm: 1'b0, exp: 3'b010};
    vecs[2]  = '{a: 8'hA5, b: 8'hA5, sm: 1'b1, exp: 3'b010};
    vecs[3]  = '{a: 8'h80, b: 8'h7F, sm: 1'b0, exp: 3'b001};
    vecs[4]  = '{a: 8'h80, b: 8'h7F, sm: 1'b1, exp: 3'b100};
    vecs[5]  = '{a: 8'h00, b: 8'hFF, sm: 1'b0, exp: 3'b100};
    vecs[6]  = '{a: 8'h80, b: 8'h80, sm: 1'b1, exp: 3'b010};
    vecs[7]  = '{a: 8'h7F, b: 8'h7F, sm: 1'b1, exp: 3'b010};
    vecs[8]  = '{a: 8'hFF, b: 8'h00, sm: 1'b1, exp: 3'b100};
    vecs[9]  = '{a: 8'hFF, b: 8'h00, sm: 1'b0, exp: 3'b001};
    vecs[10] = '{a: 8'h03, b: 8'h01, sm: 1'b0, exp: 3'b001};
    vecs[11] = '{a: 8'hC0, b: 8'hC1, sm: 1'b1, exp: 3'b100};
    vecs[12] = '{a: 8'h7F, b: 8'h80, sm: 1'b1, exp: 3'b001};
    vecs[13] = '{a: 8'h00, b: 8'h00, sm: 1'b0, exp: 3'b010};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({busy, done, lt, eq, gt}), 0);
    rst = 1'b0;
    fork monitor(); join_none

    // Table-driven compares.
    for (int i = 0; i < 14; i++) begin
      wait_idle();
      start_cmp(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp);
      wait_idle();
      chk($sformatf("sb_empty_v%0d", i), sb.size(), 0);
      chk($sformatf("busy_len_v%0d", i), blen, ref_k(vecs[i].a, vecs[i].b) + 1);
    end

    // start during RUN is ignored.
    wait_idle();
    d0 = done_cnt;
    a = 8'h10; b = 8'h20; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{exp: 3'b100, e0: cyc, k: ref_k(8'h10, 8'h20)});
    @(negedge clk);
    a = 8'hFF; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    #1;
    chk("ignored_start_done_count", done_cnt - d0, 1);
    chk("ignored_start_busy", int'(busy), 0);

    // Reset in the middle of a compare.
    start_cmp(8'h01, 8'h03, 1'b0, 3'b100);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", int'({busy, done, lt, eq, gt}), 0);
    sb.delete();
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_done_after_reset", done_cnt - d0, 0);
    wait_idle();
    start_cmp(8'h7F, 8'h7F, 1'b0, 3'b010);
    wait_idle();
    chk("post_reset_sb_empty", sb.size(), 0);

    // start held high: back-to-back compares with cycling operands.
    prev = 0; prevk = 0;
    for (int i = 0; i < 6; i++) begin
      int n;
      n = 0;
      while (busy && n < 100) begin
        @(negedge clk); #1;
        n++;
      end
      if (n >= 100) chk("held_start_timeout", 1, 0);
      x = (i == 0) ? 8'h80 : WIDTH'($urandom);
      y = (i == 0) ? 8'h7F : ((i == 3) ? x : WIDTH'($urandom));
      s = (i % 2 == 0);
      a = x; b = y; signed_mode = s; start = 1'b1;
      @(posedge clk); #1;
      kk = ref_k(x, y);
      sb.push_back('{exp: ref_cmp(x, y, s), e0: cyc, k: kk});
      if (i > 0) chk($sformatf("restart_interval_%0d", i), cyc - prev, prevk + 2);
      prev = cyc; prevk = kk;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
